instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of the single-cycle datapath: owns the word-indexed PC, issues reads to

---
 rtl/cpu_pkg.sv | 15 +
 rtl/instr_fetch_unit_if.sv | 35 +++
 rtl/instr_fetch_unit_fetch_fifo.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: widths, reset PC and fetch FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int              PC_W     = 32;
  localparam int              INSTR_W  = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response, decoder handshake, redirect.
// Latency: n/a (wires only).
// Backpressure: imem_req_ready and instr_ready throttle; imem responses are never stalled.
// Ports (master = fetch unit): drives imem_req_*, instr_valid/data/pc;
//   receives imem_req_ready, imem_rsp_*, instr_ready, redirect_*.
interface instr_fetch_unit_if #(
  parameter int PC_W = cpu_pkg::PC_W
);
  import cpu_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    instr_pc;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_target;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_target
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Generic synchronous FIFO (module fetch_fifo) with occupancy count and flush.
// Latency: a word pushed in cycle N is visible at the head in cycle N+1.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: clk, reset (async active-low), flush, push/push_data, pop/pop_data (head, 0 when empty), count.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count
);

  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Storage is not reset; masking keeps the head at zero whenever nothing is buffered.
  assign pop_data = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads, buffers words, presents {instr, pc} to decode.
// Latency: request accept to instr_valid = memory latency + 1 cycle.
// Backpressure: requests issued only while buffered + outstanding < DEPTH; instr_ready pops the head.
// Ports: clk, reset (async active-low), bus (instr_fetch_unit_if.master).
module instr_fetch_unit #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  import cpu_pkg::*;

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  fetch_state_e            state, state_nxt;
  logic [PC_W-1:0]         fetch_pc;
  logic [CW-1:0]           outstanding, outstanding_nxt, discard;
  logic [CW-1:0]           fifo_count, tag_count;
  logic [CW:0]             in_use;
  logic                    req_valid, req_fire, rsp_take, redirect;
  logic [PC_W-1:0]         tag_pc;
  logic [INSTR_W+PC_W-1:0] head;

  assign redirect = bus.redirect_valid;
  // Outstanding requests each reserve a FIFO slot, so responses can never overflow it.
  assign in_use   = {1'b0, fifo_count} + {1'b0, outstanding};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    case (state)
      FS_IDLE: state_nxt = FS_RUN;
      FS_RUN:  req_valid = !redirect && (in_use < DEPTH_C);
      default: state_nxt = FS_IDLE;
    endcase
  end

  assign req_fire        = req_valid && bus.imem_req_ready;
  assign rsp_take        = bus.imem_rsp_valid && (discard == '0);
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= bus.redirect_target;
        discard  <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_W'(1);
        if (bus.imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  // Tags of dropped responses were flushed at the redirect, so only kept responses pop a tag.
  fetch_fifo #(.W(PC_W), .DEPTH(DEPTH), .CW(CW)) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_take),
    .pop_data  (tag_pc),
    .count     (tag_count)
  );

  fetch_fifo #(.W(INSTR_W + PC_W), .DEPTH(DEPTH), .CW(CW)) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (rsp_take),
    .push_data ({bus.imem_rsp_data, tag_pc}),
    .pop       (bus.instr_ready),
    .pop_data  (head),
    .count     (fifo_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = (fifo_count != '0);
  assign {bus.instr_data, bus.instr_pc} = head;

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!reset)
    bus.imem_rsp_valid |-> (outstanding != '0));

  a_occupancy_bound: assert property (@(posedge clk) disable iff (!reset)
    ({1'b0, fifo_count} <= DEPTH_C) && ({1'b0, tag_count} <= DEPTH_C));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic  clk;
  logic  reset;
  int    n_chk  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  int    lat    = 1;
  int    allow  = 0;
  int    acc_cnt = 0;
  int    base;
  int    rel_cyc;
  pend_t pend[$];
  exp_t  sb[$];
  int    pop_cyc[$];

  instr_fetch_unit_if #(.PC_W(32)) bus ();

  instr_fetch_unit #(.PC_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words still pending after 200 cycles, want 0", name, sb.size());
      sb.delete();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Instruction memory: in-order responses 'lat' cycles after accept; word = addr ^ A5A50000.
  task automatic mem_model();
    int d;
    forever begin
      @(posedge clk);
      if (!reset) begin
        pend.delete();
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        d = cyc + lat;
        if (pend.size() > 0 && d <= pend[$].due) d = pend[$].due + 1;
        pend.push_back('{due: d, addr: bus.imem_req_addr});
        acc_cnt++;
      end
      cyc++;
      #2;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (reset && pend.size() > 0 && pend[0].due == cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = pend[0].addr ^ 32'hA5A5_0000;
        void'(pend.pop_front());
      end
      bus.imem_req_ready = (acc_cnt < allow);
    end
  endtask

  // Decoder-side monitor: every consumed word must match the scoreboard head.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got pc=%h data=%h, want no output", bus.instr_pc, bus.instr_data);
        end else begin
          e = sb.pop_front();
          check("word_pc", bus.instr_pc, e.pc);
          check("word_data", bus.instr_data, e.data);
          pop_cyc.push_back(cyc);
        end
      end
    end
  endtask

  initial begin
    reset               = 1'b0;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    fork
      mem_model();
      monitor();
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_instr_data", bus.instr_data, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);

    // 1: single-cycle memory, free-running decoder, PCs 0..3
    push_exp(32'h0, 32'hA5A5_0000);
    push_exp(32'h1, 32'hA5A5_0001);
    push_exp(32'h2, 32'hA5A5_0002);
    push_exp(32'h3, 32'hA5A5_0003);
    allow = 4;
    step();
    reset           = 1'b1;
    bus.instr_ready = 1'b1;
    rel_cyc         = cyc;
    pop_cyc.delete();
    @(negedge clk);
    check("t1_idle_req_valid", 32'(bus.imem_req_valid), 32'h0);
    step();
    @(negedge clk);
    check("t1_first_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("t1_first_req_addr", bus.imem_req_addr, 32'h0);
    wait_drain("t1");
    n_chk++;
    if (pop_cyc.size() < 4) begin
      n_fail++;
      $display("FAIL t1_timing: got %0d words, want 4", pop_cyc.size());
    end else begin
      check("t1_fill_cycles", 32'(pop_cyc[0] - rel_cyc), 32'd3);
      check("t1_back_to_back", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
    end

    // 2: decoder stalled for 20 cycles
    bus.instr_ready = 1'b0;
    base  = acc_cnt;
    allow = acc_cnt + 20;
    repeat (20) step();
    @(negedge clk);
    check("t2_accepts", 32'(acc_cnt - base), 32'd4);
    check("t2_req_valid_low", 32'(bus.imem_req_valid), 32'h0);
    check("t2_head_pc", bus.instr_pc, 32'h4);
    for (int p = 4; p < 12; p++) push_exp(32'(p), 32'(p) ^ 32'hA5A5_0000);
    step();
    allow           = acc_cnt + 4;
    bus.instr_ready = 1'b1;
    wait_drain("t2");

    // 3: 3-cycle memory, redirect to 0x0A with two requests in flight
    lat = 3;
    step();
    base  = acc_cnt;
    allow = acc_cnt + 2;
    step();
    step();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_000A;
    @(negedge clk);
    check("t3_in_flight", 32'(acc_cnt - base), 32'd2);
    check("t3_redirect_req_valid", 32'(bus.imem_req_valid), 32'h0);
    push_exp(32'h0000_000A, 32'hA5A5_000A);
    step();
    bus.redirect_valid = 1'b0;
    allow = acc_cnt + 1;
    wait_drain("t3");

    // 4: redirect coincides with a response and a decoder pop
    bus.instr_ready = 1'b0;
    lat   = 2;
    allow = acc_cnt + 3;
    step();
    step();
    step();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0020;
    bus.instr_ready     = 1'b1;
    push_exp(32'h0000_0020, 32'hA5A5_0020);
    push_exp(32'h0000_0021, 32'hA5A5_0021);
    @(negedge clk);
    check("t4_head_valid", 32'(bus.instr_valid), 32'h1);
    check("t4_head_pc", bus.instr_pc, 32'h0000_000B);
    step();
    bus.redirect_valid = 1'b0;
    allow = acc_cnt + 2;
    @(negedge clk);
    check("t4_flushed", 32'(bus.instr_valid), 32'h0);
    wait_drain("t4");

    // 5: PC wrap at all-ones
    lat = 1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFF;
    step();
    bus.redirect_valid = 1'b0;
    allow = acc_cnt + 2;
    push_exp(32'hFFFF_FFFF, 32'h5A5A_FFFF);
    push_exp(32'h0000_0000, 32'hA5A5_0000);
    @(negedge clk);
    check("t5_addr_max", bus.imem_req_addr, 32'hFFFF_FFFF);
    step();
    @(negedge clk);
    check("t5_addr_wrap", bus.imem_req_addr, 32'h0);
    wait_drain("t5");

    // 6: asynchronous reset with three words buffered
    bus.instr_ready = 1'b0;
    allow = acc_cnt + 3;
    repeat (5) step();
    @(negedge clk);
    check("t6_buffered_valid", 32'(bus.instr_valid), 32'h1);
    check("t6_buffered_pc", bus.instr_pc, 32'h1);
    check("t6_req_valid_pre", 32'(bus.imem_req_valid), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_async_instr_valid", 32'(bus.instr_valid), 32'h0);
    check("t6_async_instr_data", bus.instr_data, 32'h0);
    check("t6_async_instr_pc", bus.instr_pc, 32'h0);
    check("t6_async_req_valid", 32'(bus.imem_req_valid), 32'h0);
    step();
    step();
    reset           = 1'b1;
    bus.instr_ready = 1'b1;
    allow           = acc_cnt + 1;
    push_exp(32'h0, 32'hA5A5_0000);
    @(negedge clk);
    check("t6_idle_req_valid", 32'(bus.imem_req_valid), 32'h0);
    step();
    @(negedge clk);
    check("t6_first_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("t6_first_req_addr", bus.imem_req_addr, 32'h0);
    wait_drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
